adc_capture_buffer: RTL and testbench

- Upstream producer for the FSMC readout stage. Captures a fixed-length frame of 12-bit ADC samples on a trigger, using the 80 MHz ADC sample clock.
- Holds the frame in an on-chip RAM and presents frame_ready plus a random-access read port. The FSMC stage reads samples by index and returns frame_ack when it has read the last sample.
- The STM firmware initiates acquisition by pulsing arm.

---
 rtl/adc_capture_pkg.sv | 25 ++
 rtl/capture_ram.sv | 29 ++
 rtl/adc_capture_buffer.sv | 144 ++++++++++++++
 tb/tb_adc_capture_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types, widths and helpers for the ADC capture buffer.
// Optional build macro: ADC_TEST_PATTERN_EN (stores a deterministic ramp instead of ADC data).
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READY   = 2'd3
    } cap_state_e;

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned RD_W     = 16;
    localparam int unsigned RAM_W    = SAMPLE_W + 1;
    localparam int unsigned DECIM_W  = 8;

    localparam logic [SAMPLE_W-1:0] TP_BASE = 12'h4D2;
    localparam logic [SAMPLE_W-1:0] TP_STEP = 12'h010;

    // Read-port word layout: over-range flag in bit 15, sample in [11:0].
    function automatic logic [RD_W-1:0] pack_rd(input logic otr, input logic [SAMPLE_W-1:0] sample);
        return {otr, 3'b000, sample};
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port, no reset.
// A same-cycle read of the address being written returns the previous contents.
module capture_ram #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port (old data on collision)
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered fixed-length capture of 12-bit ADC samples into on-chip RAM with a
// random-access read port and frame_ready/frame_ack handshake toward the readout stage.
// Optional build macro: ADC_TEST_PATTERN_EN replaces stored samples with a ramp.
module adc_capture_buffer
    import adc_capture_pkg::*;
#(
    parameter int unsigned DEPTH  = 10,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DECIM  = 1
) (
    input  logic                clk_80mhz,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_otr,
    input  logic                arm,
    input  logic                trig,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [RD_W-1:0]     rd_data,
    output logic                frame_ready,
    input  logic                frame_ack,
    output logic                busy,
    output logic [7:0]          missed_trig
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]    DEPTH_X    = (ADDR_W + 1)'(DEPTH);
    localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(DECIM - 1);

    cap_state_e          state;
    logic [SAMPLE_W-1:0] s_data;
    logic                s_otr;
    logic                trig_q;
    logic                trig_qq;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DECIM_W-1:0]  decim_cnt;
    logic                rd_zero;
    logic [RAM_W-1:0]    ram_q;
    logic                trig_edge_c;
    logic                wr_en_c;
    logic [RAM_W-1:0]    wr_word_c;

    assign trig_edge_c = trig_q & ~trig_qq;
    // A write coinciding with rst is suppressed so an aborted frame gets no extra sample.
    assign wr_en_c     = (state == CAPTURE) && (decim_cnt == '0) && !rst;

`ifdef ADC_TEST_PATTERN_EN
    assign wr_word_c = {1'b0, TP_BASE + SAMPLE_W'(wr_addr) * TP_STEP};
`else
    assign wr_word_c = {s_otr, s_data};
`endif

    // Input alignment: one register stage for ADC data, two for trigger edge detection
    always_ff @(posedge clk_80mhz) begin
        s_data <= adc_data;
        s_otr  <= adc_otr;
        if (rst) begin
            trig_q  <= 1'b0;
            trig_qq <= 1'b0;
        end else begin
            trig_q  <= trig;
            trig_qq <= trig_q;
        end
    end

    // Capture FSM with registered status outputs
    always_ff @(posedge clk_80mhz) begin
        if (rst) begin
            state       <= IDLE;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            missed_trig <= 8'd0;
            wr_addr     <= '0;
            decim_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (trig_edge_c) begin
                        state     <= CAPTURE;
                        wr_addr   <= '0;
                        decim_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    if (decim_cnt == DECIM_LAST) begin
                        decim_cnt <= '0;
                    end else begin
                        decim_cnt <= decim_cnt + DECIM_W'(1);
                    end
                    if (decim_cnt == '0) begin
                        if (wr_addr == LAST_ADDR) begin
                            state       <= READY;
                            frame_ready <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
                end
                READY: begin
                    if (frame_ack) begin
                        state       <= IDLE;
                        frame_ready <= 1'b0;
                    end
                    if (trig_edge_c && (missed_trig != 8'hFF)) begin
                        missed_trig <= missed_trig + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Out-of-range reads and reset force the read word to zero, aligned with the RAM latency
    always_ff @(posedge clk_80mhz) begin
        if (rst) begin
            rd_zero <= 1'b1;
        end else begin
            rd_zero <= ({1'b0, rd_addr} >= DEPTH_X);
        end
    end

    capture_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk     (clk_80mhz),
        .we      (wr_en_c),
        .wr_addr (wr_addr),
        .wr_data (wr_word_c),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    assign rd_data = rd_zero ? '0 : pack_rd(ram_q[SAMPLE_W], ram_q[SAMPLE_W-1:0]);

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer: one DECIM=1 and one DECIM=4 instance share stimulus.
// With ADC_TEST_PATTERN_EN defined the expected samples follow the ramp.
module tb_adc_capture_buffer;

    localparam int unsigned DEPTH  = 10;
    localparam int unsigned ADDR_W = 4;

    logic              clk_80mhz = 1'b0;
    logic              rst       = 1'b1;
    logic [11:0]       adc_data  = 12'd0;
    logic              adc_otr   = 1'b0;
    logic              arm       = 1'b0;
    logic              trig      = 1'b0;
    logic [ADDR_W-1:0] rd_addr   = '0;
    logic              frame_ack = 1'b0;

    logic [15:0] rd_data_d1, rd_data_d4;
    logic        frame_ready_d1, frame_ready_d4;
    logic        busy_d1, busy_d4;
    logic [7:0]  missed_trig_d1, missed_trig_d4;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int otr_cyc = -1;

    always #5 clk_80mhz = ~clk_80mhz;

    adc_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DECIM(1)) u_dut_d1 (
        .clk_80mhz   (clk_80mhz),
        .rst         (rst),
        .adc_data    (adc_data),
        .adc_otr     (adc_otr),
        .arm         (arm),
        .trig        (trig),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data_d1),
        .frame_ready (frame_ready_d1),
        .frame_ack   (frame_ack),
        .busy        (busy_d1),
        .missed_trig (missed_trig_d1)
    );

    adc_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DECIM(4)) u_dut_d4 (
        .clk_80mhz   (clk_80mhz),
        .rst         (rst),
        .adc_data    (adc_data),
        .adc_otr     (adc_otr),
        .arm         (arm),
        .trig        (trig),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data_d4),
        .frame_ready (frame_ready_d4),
        .frame_ack   (frame_ack),
        .busy        (busy_d4),
        .missed_trig (missed_trig_d4)
    );

    // Advance to the next falling edge and present the ramp sample for this cycle
    task automatic tick();
        @(negedge clk_80mhz);
        cyc      = cyc + 1;
        adc_data = 12'(100 + cyc);
        adc_otr  = (cyc == otr_cyc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks += 8;
        if (busy_d1 !== 1'b0)        begin errors++; $display("FAIL reset busy_d1 got %b exp 0", busy_d1); end
        if (busy_d4 !== 1'b0)        begin errors++; $display("FAIL reset busy_d4 got %b exp 0", busy_d4); end
        if (frame_ready_d1 !== 1'b0) begin errors++; $display("FAIL reset frame_ready_d1 got %b exp 0", frame_ready_d1); end
        if (frame_ready_d4 !== 1'b0) begin errors++; $display("FAIL reset frame_ready_d4 got %b exp 0", frame_ready_d4); end
        if (missed_trig_d1 !== 8'd0) begin errors++; $display("FAIL reset missed_trig_d1 got %0d exp 0", missed_trig_d1); end
        if (missed_trig_d4 !== 8'd0) begin errors++; $display("FAIL reset missed_trig_d4 got %0d exp 0", missed_trig_d4); end
        if (rd_data_d1 !== 16'h0000) begin errors++; $display("FAIL reset rd_data_d1 got %h exp 0000", rd_data_d1); end
        if (rd_data_d4 !== 16'h0000) begin errors++; $display("FAIL reset rd_data_d4 got %h exp 0000", rd_data_d4); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_trig();
        trig = 1'b1;
        tick(); tick(); tick(); tick();
        checks += 4;
        if (busy_d1 !== 1'b0)        begin errors++; $display("FAIL idle_trig busy_d1 got %b exp 0", busy_d1); end
        if (busy_d4 !== 1'b0)        begin errors++; $display("FAIL idle_trig busy_d4 got %b exp 0", busy_d4); end
        if (frame_ready_d1 !== 1'b0) begin errors++; $display("FAIL idle_trig frame_ready_d1 got %b exp 0", frame_ready_d1); end
        if (missed_trig_d1 !== 8'd0) begin errors++; $display("FAIL idle_trig missed_trig_d1 got %0d exp 0", missed_trig_d1); end
        trig = 1'b0;
        tick(); tick();
    endtask

    // Arm, ack while armed, trigger, arm again mid-capture, then check timing and read back
    task automatic run_frame(input string tag);
        int          t0;
        logic        exp_fr1, exp_fr4;
        logic [15:0] exp1, exp4;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks += 2;
        if (busy_d1 !== 1'b1) begin errors++; $display("FAIL %s armed busy_d1 got %b exp 1", tag, busy_d1); end
        if (busy_d4 !== 1'b1) begin errors++; $display("FAIL %s armed busy_d4 got %b exp 1", tag, busy_d4); end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        tick();
        checks += 2;
        if (busy_d1 !== 1'b1 || frame_ready_d1 !== 1'b0)
            begin errors++; $display("FAIL %s ack_in_armed d1 busy %b ready %b exp 1 0", tag, busy_d1, frame_ready_d1); end
        if (busy_d4 !== 1'b1 || frame_ready_d4 !== 1'b0)
            begin errors++; $display("FAIL %s ack_in_armed d4 busy %b ready %b exp 1 0", tag, busy_d4, frame_ready_d4); end

        t0      = cyc;
        trig    = 1'b1;
        otr_cyc = t0 + 4;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 4) arm = 1'b1;
            if (k == 5) arm = 1'b0;
            exp_fr1 = (cyc >= t0 + 12);
            exp_fr4 = (cyc >= t0 + 39);
            checks += 4;
            if (frame_ready_d1 !== exp_fr1) begin errors++; $display("FAIL %s frame_ready_d1 k=%0d got %b exp %b", tag, k, frame_ready_d1, exp_fr1); end
            if (frame_ready_d4 !== exp_fr4) begin errors++; $display("FAIL %s frame_ready_d4 k=%0d got %b exp %b", tag, k, frame_ready_d4, exp_fr4); end
            if (busy_d1 !== !exp_fr1)       begin errors++; $display("FAIL %s busy_d1 k=%0d got %b exp %b", tag, k, busy_d1, !exp_fr1); end
            if (busy_d4 !== !exp_fr4)       begin errors++; $display("FAIL %s busy_d4 k=%0d got %b exp %b", tag, k, busy_d4, !exp_fr4); end
        end
        trig    = 1'b0;
        otr_cyc = -1;

        for (int i = 0; i <= 11; i++) begin
            rd_addr = (i == 11) ? ADDR_W'(15) : ADDR_W'(i);
            tick();
            if (i >= 10) begin
                exp1 = 16'h0000;
                exp4 = 16'h0000;
            end else begin
`ifdef ADC_TEST_PATTERN_EN
                exp1 = {4'b0000, 12'h4D2 + 12'(16 * i)};
                exp4 = exp1;
`else
                exp1 = {(i == 3), 3'b000, 12'(100 + t0 + 1 + i)};
                exp4 = {1'b0, 3'b000, 12'(100 + t0 + 1 + 4 * i)};
`endif
            end
            checks += 2;
            if (rd_data_d1 !== exp1) begin errors++; $display("FAIL %s rd_data_d1 addr=%0d got %h exp %h", tag, rd_addr, rd_data_d1, exp1); end
            if (rd_data_d4 !== exp4) begin errors++; $display("FAIL %s rd_data_d4 addr=%0d got %h exp %h", tag, rd_addr, rd_data_d4, exp4); end
        end
        rd_addr = '0;
    endtask

    task automatic test_handshake();
        tick(); tick();
        for (int e = 0; e < 3; e++) begin
            trig = 1'b1;
            tick();
            trig = 1'b0;
            tick();
        end
        tick(); tick();
        checks += 4;
        if (missed_trig_d1 !== 8'd3) begin errors++; $display("FAIL handshake missed_trig_d1 got %0d exp 3", missed_trig_d1); end
        if (missed_trig_d4 !== 8'd3) begin errors++; $display("FAIL handshake missed_trig_d4 got %0d exp 3", missed_trig_d4); end
        if (frame_ready_d1 !== 1'b1) begin errors++; $display("FAIL handshake hold frame_ready_d1 got %b exp 1", frame_ready_d1); end
        if (frame_ready_d4 !== 1'b1) begin errors++; $display("FAIL handshake hold frame_ready_d4 got %b exp 1", frame_ready_d4); end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        checks += 3;
        if (frame_ready_d1 !== 1'b0 || busy_d1 !== 1'b0)
            begin errors++; $display("FAIL handshake ack d1 ready %b busy %b exp 0 0", frame_ready_d1, busy_d1); end
        if (frame_ready_d4 !== 1'b0 || busy_d4 !== 1'b0)
            begin errors++; $display("FAIL handshake ack d4 ready %b busy %b exp 0 0", frame_ready_d4, busy_d4); end
        tick(); tick();
        if (missed_trig_d1 !== 8'd3) begin errors++; $display("FAIL handshake keep missed_trig_d1 got %0d exp 3", missed_trig_d1); end
    endtask

    task automatic test_midcapture_reset();
        int t0;
        arm = 1'b1;
        tick();
        arm  = 1'b0;
        t0   = cyc;
        trig = 1'b1;
        while (cyc < t0 + 7) tick();
        rst = 1'b1;
        tick();
        checks += 6;
        if (busy_d1 !== 1'b0)        begin errors++; $display("FAIL midreset busy_d1 got %b exp 0", busy_d1); end
        if (busy_d4 !== 1'b0)        begin errors++; $display("FAIL midreset busy_d4 got %b exp 0", busy_d4); end
        if (frame_ready_d1 !== 1'b0) begin errors++; $display("FAIL midreset frame_ready_d1 got %b exp 0", frame_ready_d1); end
        if (frame_ready_d4 !== 1'b0) begin errors++; $display("FAIL midreset frame_ready_d4 got %b exp 0", frame_ready_d4); end
        if (missed_trig_d1 !== 8'd0) begin errors++; $display("FAIL midreset missed_trig_d1 got %0d exp 0", missed_trig_d1); end
        if (missed_trig_d4 !== 8'd0) begin errors++; $display("FAIL midreset missed_trig_d4 got %0d exp 0", missed_trig_d4); end
        rst  = 1'b0;
        trig = 1'b0;
        tick(); tick();
        run_frame("fresh_frame");
    endtask

    initial begin
        test_reset();
        test_idle_trig();
        run_frame("basic_frame");
        test_handshake();
        test_midcapture_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
